ram_lane_master: RTL and testbench
==================================

Name: ram_lane_master

Overview:
- Command-driven initiator for the three-lane data RAM: turns a strided load/store request into RAM read/write cycles.
- Each RAM access moves three words, one per lane.
- Sits between the processor datapath (3x3 matrix load/store) and the RAM's read/write/address/data ports.
- Generates lane addresses, bursts over rows, returns read data with valid/ready back-pressure.

Parameters:
- DATA_LEN, 16, width of one memory word.
- ADDRESS_LEN, 8, width of one lane address; all address arithmetic is modulo 2^ADDRESS_LEN.
- ROW_CNT_W, 4, width of the row-count field.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_write  input  1  1 = store, 0 = load.
- cmd_base  input  ADDRESS_LEN  lane-0 address of row 0.
- cmd_stride  input  ADDRESS_LEN  address step between lanes.
- cmd_row_step  input  ADDRESS_LEN  base increment between rows.
- cmd_rows  input  ROW_CNT_W  number of rows to transfer.
- wr_data  input  DATA_LEN*3  store data; lane 0 in the low bits.
- wr_data_valid  input  1  store data offered.
- wr_data_ready  output  1  store data accepted.
- rd_data  output  DATA_LEN*3  load data; lane 0 in the low bits.
- rd_valid  output  1  load data present.
- rd_ready  input  1  load data consumed.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at command completion.
- ram_read  output  1  to RAM read.
- ram_write  output  1  to RAM write.
- ram_address  output  ADDRESS_LEN*3  to RAM; lane 0 in the low bits.
- ram_data_in  output  DATA_LEN*3  to RAM write data.
- ram_data_out  input  DATA_LEN*3  from RAM; registered, valid the cycle after ram_read.

Behaviour:
- Reset values: all outputs 0, state IDLE, row counter 0. Exception: cmd_ready is 1 during and after reset.
- Registered outputs: all outputs except cmd_ready, wr_data_ready and busy are registered. Those three decode directly from state.
- Lane addresses per row r: rowbase = cmd_base + r*cmd_row_step; lane0 = rowbase, lane1 = rowbase + stride, lane2 = rowbase + 2*stride. All sums truncate to ADDRESS_LEN bits (wrap). Base, stride, row_step, rows and write flag are latched at command accept.
- IDLE: cmd_valid & cmd_ready accepts a command.
  - rows == 0: pulse done next cycle, stay IDLE, no RAM access.
  - Otherwise go to RD_ISSUE (load) or WR_ACCEPT (store).
- RD_ISSUE: one cycle, ram_read = 1 with row addresses -> RD_WAIT.
- RD_WAIT: one cycle, ram_read = 0. rd_data <= ram_data_out at the end of the cycle -> RD_RESP.
- RD_RESP: rd_valid = 1. rd_data stays stable until rd_valid & rd_ready. On that handshake rd_valid drops next cycle, and:
  - rows remain: go to RD_ISSUE.
  - last row: pulse done, go to IDLE.
- Load latency: command accept edge -> ram_read high the next cycle -> rd_valid high 3 cycles after accept.
- WR_ACCEPT: wr_data_ready = 1. On wr_data_valid, latch wr_data into ram_data_in -> WR_ISSUE.
- WR_ISSUE: one cycle, ram_write = 1 with row addresses and latched data. Then:
  - rows remain: go to WR_ACCEPT.
  - last row: pulse done, go to IDLE.
- Mutual exclusion: ram_read and ram_write are never high together. Each is high for exactly one cycle per row.
- Aliasing: aliased lane addresses (stride 0 or wrap collisions) are not checked. On a store, the RAM resolves them with lane 2 winning.
- Reset mid-operation: immediate return to IDLE.
  - rd_valid, ram_read, ram_write and done are cleared.
  - Pending data is discarded.
  - No further RAM access occurs.
- Ignored inputs: cmd_valid outside IDLE, rd_ready outside RD_RESP, and wr_data_valid outside WR_ACCEPT have no effect.

Test Plan:
- Contiguous load: RAM preloaded mem[62..64] = 3,3,2. Command load base 62, stride 1, rows 1 -> ram_address = {64,63,62} for exactly one ram_read cycle. rd_valid rises 3 cycles after accept with rd_data = {2,3,3}. done pulses after the handshake.
- Strided burst: mem[64] = 2, mem[65] = 1, mem[67] = 5, mem[68] = 4, mem[70] = 44, mem[71] = 33. Command load base 64, stride 3, row_step 1, rows 2 -> row 0 rd_data {44,5,2}, row 1 rd_data {33,4,1}. Exactly two ram_read pulses; done pulses once, after the second handshake.
- Store then readback: store base 82, stride 1, rows 1 with wr_data {9,8,7} -> one ram_write cycle with address {84,83,82}. A following load of the same addresses returns {9,8,7}.
- Back-pressure: during a load, hold rd_ready low 5 cycles in RD_RESP -> rd_valid and rd_data stay constant, no extra ram_read, cmd_ready stays 0.
- Wrap and zero rows: base 0xFE, stride 1 -> ram_address lanes {0x00,0xFF,0xFE}. A command with rows 0 -> done pulse, no ram_read or ram_write.
- Reset mid-burst: assert reset during RD_WAIT of a 3-row load -> all outputs 0 asynchronously. After release cmd_ready = 1 and no RAM strobes occur until a new command.

Source files
------------

// File: rtl/ram_lane_master.sv
// Strided three-lane RAM initiator: turns a load/store command into one RAM
// access per row, with valid/ready return of load data.
module ram_lane_master #(
    parameter int DATA_LEN    = 16,
    parameter int ADDRESS_LEN = 8,
    parameter int ROW_CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_LEN-1:0]   cmd_base,
    input  logic [ADDRESS_LEN-1:0]   cmd_stride,
    input  logic [ADDRESS_LEN-1:0]   cmd_row_step,
    input  logic [ROW_CNT_W-1:0]     cmd_rows,
    input  logic [DATA_LEN*3-1:0]    wr_data,
    input  logic                     wr_data_valid,
    output logic                     wr_data_ready,
    output logic [DATA_LEN*3-1:0]    rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_read,
    output logic                     ram_write,
    output logic [ADDRESS_LEN*3-1:0] ram_address,
    output logic [DATA_LEN*3-1:0]    ram_data_in,
    input  logic [DATA_LEN*3-1:0]    ram_data_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_WAIT   = 3'd2,
        RD_RESP   = 3'd3,
        WR_ACCEPT = 3'd4,
        WR_ISSUE  = 3'd5
    } state_t;

    state_t                 state_r;
    logic [ADDRESS_LEN-1:0] rowbase_r;
    logic [ADDRESS_LEN-1:0] stride_r;
    logic [ADDRESS_LEN-1:0] row_step_r;
    logic [ROW_CNT_W-1:0]   rows_left_r;
    logic [ADDRESS_LEN-1:0] next_rowbase_s;

    // Packs {lane2, lane1, lane0}; sums wrap at ADDRESS_LEN bits.
    function automatic logic [ADDRESS_LEN*3-1:0] lane_addrs(
        input logic [ADDRESS_LEN-1:0] base,
        input logic [ADDRESS_LEN-1:0] stride
    );
        logic [ADDRESS_LEN-1:0] a1;
        logic [ADDRESS_LEN-1:0] a2;
        a1 = base + stride;
        a2 = a1 + stride;
        return {a2, a1, base};
    endfunction

    assign next_rowbase_s = rowbase_r + row_step_r;
    assign cmd_ready      = (state_r == IDLE);
    assign busy           = (state_r != IDLE);
    assign wr_data_ready  = (state_r == WR_ACCEPT);

    // Command sequencer with registered RAM strobes, read data and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rowbase_r   <= {ADDRESS_LEN{1'b0}};
            stride_r    <= {ADDRESS_LEN{1'b0}};
            row_step_r  <= {ADDRESS_LEN{1'b0}};
            rows_left_r <= {ROW_CNT_W{1'b0}};
            rd_data     <= {(DATA_LEN*3){1'b0}};
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= {(ADDRESS_LEN*3){1'b0}};
            ram_data_in <= {(DATA_LEN*3){1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_rows == {ROW_CNT_W{1'b0}}) begin
                            done <= 1'b1;
                        end else begin
                            rowbase_r   <= cmd_base;
                            stride_r    <= cmd_stride;
                            row_step_r  <= cmd_row_step;
                            rows_left_r <= cmd_rows - ROW_CNT_W'(1);
                            ram_address <= lane_addrs(cmd_base, cmd_stride);
                            if (cmd_write) begin
                                state_r <= WR_ACCEPT;
                            end else begin
                                ram_read <= 1'b1;
                                state_r  <= RD_ISSUE;
                            end
                        end
                    end
                end
                RD_ISSUE: begin
                    ram_read <= 1'b0;
                    state_r  <= RD_WAIT;
                end
                RD_WAIT: begin
                    rd_data  <= ram_data_out;
                    rd_valid <= 1'b1;
                    state_r  <= RD_RESP;
                end
                RD_RESP: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (rows_left_r == {ROW_CNT_W{1'b0}}) begin
                            done    <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            rowbase_r   <= next_rowbase_s;
                            rows_left_r <= rows_left_r - ROW_CNT_W'(1);
                            ram_address <= lane_addrs(next_rowbase_s, stride_r);
                            ram_read    <= 1'b1;
                            state_r     <= RD_ISSUE;
                        end
                    end
                end
                WR_ACCEPT: begin
                    if (wr_data_valid) begin
                        ram_data_in <= wr_data;
                        ram_write   <= 1'b1;
                        state_r     <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    ram_write <= 1'b0;
                    if (rows_left_r == {ROW_CNT_W{1'b0}}) begin
                        done    <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        rowbase_r   <= next_rowbase_s;
                        rows_left_r <= rows_left_r - ROW_CNT_W'(1);
                        ram_address <= lane_addrs(next_rowbase_s, stride_r);
                        state_r     <= WR_ACCEPT;
                    end
                end
                default: begin
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    rd_valid  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_lane_master.sv
// Scoreboard bench for ram_lane_master with a behavioural registered RAM;
// expected addresses and load data are queued at issue and popped by a monitor.
module tb_ram_lane_master;

    localparam int DL = 16;
    localparam int AL = 8;
    localparam int RW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AL-1:0]   cmd_base, cmd_stride, cmd_row_step;
    logic [RW-1:0]   cmd_rows;
    logic [3*DL-1:0] wr_data;
    logic            wr_data_valid, wr_data_ready;
    logic [3*DL-1:0] rd_data;
    logic            rd_valid, rd_ready, busy, done;
    logic            ram_read, ram_write;
    logic [3*AL-1:0] ram_address;
    logic [3*DL-1:0] ram_data_in;
    logic [3*DL-1:0] ram_data_out = '0;

    logic [DL-1:0]   mem [0:255];
    logic            pl_en = 1'b0;
    logic [AL-1:0]   pl_addr = '0;
    logic [DL-1:0]   pl_data = '0;

    int checks = 0, failures = 0;
    int n_read = 0, n_write = 0, n_done = 0, n_overlap = 0;
    int r0, w0, d0;
    logic [3*AL-1:0] exp_addr_q[$];
    logic [3*DL-1:0] exp_rd_q[$];
    logic [3*DL-1:0] exp_wd_q[$];

    ram_lane_master #(.DATA_LEN(DL), .ADDRESS_LEN(AL), .ROW_CNT_W(RW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_row_step(cmd_row_step),
        .cmd_rows(cmd_rows),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Registered RAM; on aliased store addresses lane 2 is written last and wins.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (ram_read)
            ram_data_out <= {mem[ram_address[23:16]], mem[ram_address[15:8]], mem[ram_address[7:0]]};
        if (ram_write) begin
            mem[ram_address[7:0]]   <= ram_data_in[15:0];
            mem[ram_address[15:8]]  <= ram_data_in[31:16];
            mem[ram_address[23:16]] <= ram_data_in[47:32];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Monitor: counts strobes and pops the scoreboards on RAM accesses and handshakes.
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_read && ram_write) n_overlap++;
            if (ram_read) n_read++;
            if (ram_write) n_write++;
            if (done) n_done++;
            if (ram_read || ram_write) begin
                if (exp_addr_q.size() == 0) unexpected("ram_address", ram_address);
                else check("ram_address", ram_address, exp_addr_q.pop_front());
            end
            if (ram_write) begin
                if (exp_wd_q.size() == 0) unexpected("ram_data_in", ram_data_in);
                else check("ram_data_in", ram_data_in, exp_wd_q.pop_front());
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) unexpected("rd_data", rd_data);
                else check("rd_data", rd_data, exp_rd_q.pop_front());
            end
        end
    end

    task automatic preload(input logic [AL-1:0] a, input logic [DL-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [AL-1:0] base, input logic [AL-1:0] stride,
                         input logic [AL-1:0] step, input logic [RW-1:0] rows);
        check("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = base;
        cmd_stride = stride; cmd_row_step = step; cmd_rows = rows;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) unexpected({name, "_done_timeout"}, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rv(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (rd_valid) seen = 1'b1;
        end
        if (!seen) unexpected({name, "_rd_valid_timeout"}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0;
        cmd_stride = '0; cmd_row_step = '0; cmd_rows = '0;
        wr_data = '0; wr_data_valid = 1'b0; rd_ready = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_strobes", {ram_read, ram_write, done, wr_data_ready}, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_rd_data", rd_data, 0);

        preload(8'd62, 16'd3);  preload(8'd63, 16'd3);  preload(8'd64, 16'd2);
        preload(8'd65, 16'd1);  preload(8'd67, 16'd5);  preload(8'd68, 16'd4);
        preload(8'd70, 16'd44); preload(8'd71, 16'd33);
        preload(8'hFE, 16'h11); preload(8'hFF, 16'h22); preload(8'h00, 16'h33);
        reset = 1'b0;
        @(posedge clk); #1;

        // Contiguous load with latency checks
        r0 = n_read; d0 = n_done;
        exp_addr_q.push_back({8'd64, 8'd63, 8'd62});
        exp_rd_q.push_back({16'd2, 16'd3, 16'd3});
        issue(1'b0, 8'd62, 8'd1, 8'd0, 4'd1);
        check("t1_ram_read_c1", ram_read, 1);
        check("t1_busy", {busy, cmd_ready}, 2'b10);
        @(posedge clk); #1;
        check("t1_c2_read_valid", {ram_read, rd_valid}, 2'b00);
        @(posedge clk); #1;
        check("t1_rd_valid_c3", rd_valid, 1);
        wait_done("t1", 20);
        check("t1_reads", n_read - r0, 1);
        check("t1_dones", n_done - d0, 1);

        // Strided two-row burst
        r0 = n_read; d0 = n_done;
        exp_addr_q.push_back({8'd70, 8'd67, 8'd64});
        exp_addr_q.push_back({8'd71, 8'd68, 8'd65});
        exp_rd_q.push_back({16'd44, 16'd5, 16'd2});
        exp_rd_q.push_back({16'd33, 16'd4, 16'd1});
        issue(1'b0, 8'd64, 8'd3, 8'd1, 4'd2);
        wait_done("t2", 40);
        check("t2_reads", n_read - r0, 2);
        check("t2_dones", n_done - d0, 1);

        // Store then readback
        r0 = n_read; w0 = n_write;
        wr_data = {16'd9, 16'd8, 16'd7}; wr_data_valid = 1'b1;
        exp_addr_q.push_back({8'd84, 8'd83, 8'd82});
        exp_wd_q.push_back({16'd9, 16'd8, 16'd7});
        issue(1'b1, 8'd82, 8'd1, 8'd0, 4'd1);
        check("t3_wr_data_ready", wr_data_ready, 1);
        wait_done("t3w", 20);
        wr_data_valid = 1'b0;
        check("t3_writes", n_write - w0, 1);
        check("t3_no_reads", n_read - r0, 0);
        exp_addr_q.push_back({8'd84, 8'd83, 8'd82});
        exp_rd_q.push_back({16'd9, 16'd8, 16'd7});
        issue(1'b0, 8'd82, 8'd1, 8'd0, 4'd1);
        wait_done("t3r", 20);

        // Back-pressure in RD_RESP
        rd_ready = 1'b0;
        exp_addr_q.push_back({8'd64, 8'd63, 8'd62});
        exp_rd_q.push_back({16'd2, 16'd3, 16'd3});
        issue(1'b0, 8'd62, 8'd1, 8'd0, 4'd1);
        wait_rv("t4", 10);
        r0 = n_read;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_hold_valid", {rd_valid, cmd_ready}, 2'b10);
            check("t4_hold_data", rd_data, {16'd2, 16'd3, 16'd3});
        end
        check("t4_no_extra_read", n_read - r0, 0);
        rd_ready = 1'b1;
        wait_done("t4", 20);

        // Address wrap, then zero-row command
        exp_addr_q.push_back({8'h00, 8'hFF, 8'hFE});
        exp_rd_q.push_back({16'h33, 16'h22, 16'h11});
        issue(1'b0, 8'hFE, 8'd1, 8'd0, 4'd1);
        wait_done("t5", 20);
        r0 = n_read; w0 = n_write; d0 = n_done;
        issue(1'b0, 8'd10, 8'd1, 8'd1, 4'd0);
        check("t5_zero_done", {done, cmd_ready, busy}, 3'b110);
        @(posedge clk); #1;
        check("t5_zero_done_drop", done, 0);
        check("t5_zero_no_access", (n_read - r0) + (n_write - w0), 0);
        check("t5_zero_dones", n_done - d0, 1);

        // Reset during RD_WAIT of a three-row load
        r0 = n_read; w0 = n_write;
        exp_addr_q.push_back({8'd70, 8'd67, 8'd64});
        issue(1'b0, 8'd64, 8'd3, 8'd1, 4'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t6_rst_strobes", {ram_read, ram_write, done, rd_valid, busy, wr_data_ready}, 0);
        check("t6_rst_cmd_ready", cmd_ready, 1);
        check("t6_rst_address", ram_address, 0);
        check("t6_rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_more_reads", n_read - r0, 1);
        check("t6_no_writes", n_write - w0, 0);
        check("t6_idle_after", {cmd_ready, busy, rd_valid}, 3'b100);

        check("addr_queue_empty", exp_addr_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        check("wd_queue_empty", exp_wd_q.size(), 0);
        check("no_read_write_overlap", n_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
